// File: rtl/cereal_pkg.sv
// Shared constants and state encoding for the cereal serial link.
package cereal_pkg;

  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned BAUD       = 9600;
  // Common bit period for both the transmitter and the receiver.
  localparam int unsigned BIT_CYCLES = CLK_HZ / BAUD;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/cereal_rx_if.sv
// Byte-side handshake between the receiver and board logic.
interface cereal_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, busy,
    input  rx_ack
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, busy,
    output rx_ack
  );
endinterface

// File: rtl/line_sync.sv
// Two-flop synchroniser for asynchronous inputs; resets to the idle-high level.
module line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Double-register the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/cereal_rx.sv
// 8N1 LSB-first serial receiver with a valid/ack byte interface.
module cereal_rx #(
  parameter int unsigned BIT_CYCLES  = cereal_pkg::BIT_CYCLES,
  parameter int unsigned HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          serialIn,
  cereal_rx_if.master   bus
);
  import cereal_pkg::*;

  localparam int unsigned CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);

  logic            line;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            busy_q, busy_d;

  line_sync u_sync (
    .clk   (sysclk),
    .rst_n (reset),
    .d_i   (serialIn),
    .q_o   (line)
  );

  // State register.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a low line at the stop sample parks in BREAK until it idles high.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (!line) state_d = ST_START;
      ST_START: if (cnt_q == HALF_LAST) state_d = line ? ST_IDLE : ST_DATA;
      ST_DATA:  if (cnt_q == BIT_LAST && bit_q == 3'd7) state_d = ST_STOP;
      ST_STOP:  if (cnt_q == BIT_LAST) state_d = line ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (line) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; a same-cycle delivery overrides an ack.
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q && !bus.rx_ack;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: cnt_d = '0;
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = 3'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[7:1]};
          if (bit_q != 3'd7) bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (line) begin
            if (!valid_q || bus.rx_ack) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_BREAK: cnt_d = '0;
      default:  cnt_d = '0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/cereal_rx.md
Name: cereal_rx

Overview:
- UART-style serial receiver; the receive-side counterpart of the cereal transmitter.
- Frame format: 8N1, LSB first, idle-high line.
- Replaces ad-hoc inline bit capture in top-level boards with a clean byte interface and a valid/ack handshake.
- Sits between the raw serialIn pin and board logic (RAM store, echo to cereal).

Parameters:
- BIT_CYCLES, 5208, sysclk cycles per bit period (50 MHz / 9600 baud); legal minimum 8.
- HALF_CYCLES, BIT_CYCLES/2, cycles from start-edge detection to the start-bit mid-point sample.

Ports:
- sysclk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- serialIn  in  1  raw asynchronous serial line; idles high.
- rx_data  out  8  last received byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ack  in  1  consumer strobe; clears rx_valid.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte dropped because rx_valid was still set.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, sync flops=1, bit counter=0, cycle counter=0, shift register=0.
  - Outputs: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset asserted mid-frame aborts the frame; no pulse is emitted.
- Input synchroniser: two flops on serialIn (reset value 1). All decisions use the second flop, called "line".
- State IDLE:
  - When line==0, go to START and clear the cycle counter.
- State START:
  - Count cycles. When the count reaches HALF_CYCLES-1, sample line.
  - line==0: go to DATA, cycle counter=0, bit index=0.
  - line==1: glitch; return to IDLE, no pulse.
- State DATA:
  - At count BIT_CYCLES-1, shift line into the MSB of the shift register (right shift, so LSB-first data lands correctly) and clear the count.
  - After bit index 7 is captured, go to STOP; otherwise increment the index.
  - Bit index is 3 bits; no wrap is possible because the state exits at 7.
- State STOP, at count BIT_CYCLES-1, sample line:
  - line==1 and (rx_valid==0 or rx_ack==1): load rx_data, set rx_valid=1 on the next edge, go to IDLE.
  - line==1 and rx_valid==1 and rx_ack==0: pulse overrun for one cycle; rx_data is kept (new byte discarded); go to IDLE.
  - line==0: pulse frame_err for one cycle; discard the byte; go to BREAK.
- State BREAK:
  - Wait for line==1, then go to IDLE. This prevents a held-low line from retriggering.
- Handshake:
  - rx_ack while rx_valid==1 clears rx_valid on the next edge.
  - rx_ack while rx_valid==0 is ignored.
  - Delivery and ack in the same cycle: delivery wins; rx_valid stays 1 with the new data, and no overrun is signalled.
- Latency:
  - rx_valid rises 2 (sync) + HALF_CYCLES + 9*BIT_CYCLES + 1 cycles after the serialIn falling edge.
  - A new start bit is accepted on the cycle after returning to IDLE, so back-to-back frames with a single stop bit are received.
- Width rules:
  - Cycle counter width is clog2(BIT_CYCLES).
  - Counter comparisons are equality only; the counter never wraps unobserved.

Decomposition:
- Package cereal_pkg holds:
  - the state encoding (IDLE, START, DATA, STOP, BREAK, 3 bits);
  - default constants CLK_HZ=50_000_000 and BAUD=9600;
  - the derived BIT_CYCLES, shared with the cereal transmitter so both sides of the link use one constant.
- One sub-module, line_sync: a 2-flop synchroniser with asynchronous active-low reset to 1. It is reusable for button and reset inputs.

Test Plan (BIT_CYCLES=16, HALF_CYCLES=8):
- Single frame 0x41, stop=1, rx_ack low:
  - rx_data=0x41, rx_valid=1 exactly 2+8+144+1=155 cycles after the start edge.
  - frame_err=0, overrun=0, busy low afterwards.
- Back-to-back 0x55 then 0xAA, with rx_ack pulsed 3 cycles after each rx_valid:
  - both bytes delivered in order, no overrun.
- Two frames 0x12, 0x34 with rx_ack never asserted:
  - rx_data stays 0x12.
  - overrun pulses exactly 1 cycle at the second stop sample.
- Frame 0x7E with the stop bit driven 0 and the line held low 40 cycles:
  - one frame_err pulse, rx_valid stays 0.
  - state holds BREAK until the line goes high, then a following 0x7E frame is received correctly.
- Start glitch: serialIn low for 4 cycles, then high:
  - return to IDLE at the mid-start sample; no outputs change.
- reset pulled low during DATA bit 4 of 0xFF, released, then frame 0x0F sent:
  - all outputs 0 during reset; rx_data=0x0F afterwards, no frame_err.
